eightbit_mem: RTL and testbench

Synthesizable memory responder for the eightbit CPU's memory port; the CPU is the initiator, this block is the target.
- Holds 256x8 RAM; serves each mem_req read/write with a one-cycle mem_ready pulse after a configurable number of wait states.
- Side load port preloads programs and data before or while the CPU runs.
- Replaces behavioural bench memory in system-level simulation and FPGA builds.

---
 rtl/eightbit_pkg.sv | 12 +
 rtl/eightbit_ram.sv | 30 +++
 rtl/eightbit_mem.sv | 119 +++++++++++
 tb/tb_eightbit_mem.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eightbit_pkg.sv
// Shared widths, depth and FSM state type for the eightbit CPU memory responder.
package eightbit_pkg;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 256;
  localparam int CNT_W     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;
endpackage

// File: rtl/eightbit_ram.sv
// 256x8 storage with a side-load write port that outranks the CPU write port,
// and a read port that returns the post-write value of the CPU address.
module eightbit_ram
  import eightbit_pkg::*;
(
  input  logic              clk,
  input  logic              i_ld_en,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_data,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  // The load write is issued last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (i_cpu_we) r_mem[i_cpu_addr] <= i_cpu_data;
    if (i_ld_en)  r_mem[i_ld_addr]  <= i_ld_data;
  end

  always_comb begin
    o_rd_data = r_mem[i_cpu_addr];
    if (i_cpu_we) o_rd_data = i_cpu_data;
    if (i_ld_en && (i_ld_addr == i_cpu_addr)) o_rd_data = i_ld_data;
  end

endmodule

// File: rtl/eightbit_mem.sv
// Memory target for the eightbit CPU: wait-state FSM, request capture and output registers.
// Optional write protection below ROM_TOP is enabled by defining EIGHTBIT_MEM_WP_EN.
module eightbit_mem
  import eightbit_pkg::*;
#(
  parameter int                WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] ROM_TOP     = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mem_req,
  input  logic              we,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              mem_ready,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              wp_fault
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_data;
  logic              w_capture;
  logic              w_acc;
  logic [ADDR_W-1:0] w_acc_addr;
  logic              w_acc_we;
  logic [DATA_W-1:0] w_acc_data;
  logic              w_wp;
  logic              w_cpu_we;
  logic [DATA_W-1:0] w_rd_data;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_acc       = 1'b0;
    w_acc_addr  = addr;
    w_acc_we    = we;
    w_acc_data  = data_in;
    case (r_state)
      IDLE: begin
        if (mem_req) begin
          if (WAIT_STATES == 0) begin
            w_acc = 1'b1;
          end else begin
            w_capture   = 1'b1;
            w_cnt_nxt   = CNT_INIT;
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // CPU pins are ignored here; the access uses the captured request.
        w_acc_addr = r_addr;
        w_acc_we   = r_we;
        w_acc_data = r_data;
        if (r_cnt == '0) begin
          w_acc       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef EIGHTBIT_MEM_WP_EN
  assign w_wp = w_acc_we && (w_acc_addr < ROM_TOP);
`else
  // ROM_TOP stays referenced so the unprotected build has no dangling parameter.
  assign w_wp = 1'b0 && (w_acc_addr < ROM_TOP);
`endif

  assign w_cpu_we = w_acc && w_acc_we && !w_wp;

  eightbit_ram u_ram (
    .clk        (clk),
    .i_ld_en    (ld_en),
    .i_ld_addr  (ld_addr),
    .i_ld_data  (ld_data),
    .i_cpu_we   (w_cpu_we),
    .i_cpu_addr (w_acc_addr),
    .i_cpu_data (w_acc_data),
    .o_rd_data  (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      mem_ready <= 1'b0;
      wp_fault  <= 1'b0;
      data_out  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      mem_ready <= w_acc;
      wp_fault  <= w_acc && w_wp;
      if (w_acc) data_out <= w_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_addr <= addr;
      r_we   <= we;
      r_data <= data_in;
    end
  end

endmodule

// File: tb/tb_eightbit_mem.sv
// Self-checking bench for eightbit_mem: three instances (0, 2 and 3 wait states)
// share the CPU and load pins but each has its own request strobe.
module tb_eightbit_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr, data_in, ld_addr, ld_data;
  logic       we, ld_en;
  logic       req0, req2, req3;
  logic [7:0] do0, do2, do3;
  logic       rdy0, rdy2, rdy3;
  logic       wp0, wp2, wp3;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];

`ifdef EIGHTBIT_MEM_WP_EN
  localparam logic WP_ON = 1'b1;
`else
  localparam logic WP_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  eightbit_mem #(.WAIT_STATES(0), .ROM_TOP(8'h08)) u_ws0 (
    .clk(clk), .rst(rst), .addr(addr), .mem_req(req0), .we(we), .data_in(data_in),
    .data_out(do0), .mem_ready(rdy0), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .wp_fault(wp0));

  eightbit_mem #(.WAIT_STATES(2), .ROM_TOP(8'h08)) u_ws2 (
    .clk(clk), .rst(rst), .addr(addr), .mem_req(req2), .we(we), .data_in(data_in),
    .data_out(do2), .mem_ready(rdy2), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .wp_fault(wp2));

  eightbit_mem #(.WAIT_STATES(3), .ROM_TOP(8'h08)) u_ws3 (
    .clk(clk), .rst(rst), .addr(addr), .mem_req(req3), .we(we), .data_in(data_in),
    .data_out(do3), .mem_ready(rdy3), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .wp_fault(wp3));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // One request on instance inst; returns the sampled outputs and cycles to ready (99 = none).
  task automatic drive_req(input int inst, input logic [7:0] a, input logic w,
                           input logic [7:0] d, output logic [7:0] dout,
                           output int lat, output logic wpf);
    logic seen;
    seen = 1'b0; lat = 0; dout = 8'h00; wpf = 1'b0;
    addr = a; we = w; data_in = d;
    case (inst)
      0: req0 = 1'b1;
      2: req2 = 1'b1;
      default: req3 = 1'b1;
    endcase
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin req0 = 1'b0; req2 = 1'b0; req3 = 1'b0; we = 1'b0; end
      case (inst)
        0: begin seen = rdy0; dout = do0; wpf = wp0; end
        2: begin seen = rdy2; dout = do2; wpf = wp2; end
        default: begin seen = rdy3; dout = do3; wpf = wp3; end
      endcase
    end
    if (!seen) lat = 99;
  endtask

  task automatic test_reset();
    rst = 1'b1; addr = 0; we = 0; data_in = 0; ld_en = 0; ld_addr = 0; ld_data = 0;
    req0 = 0; req2 = 0; req3 = 0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL reset_rdy0: got %b want 0", rdy0); end
    n_cmp++; if (do0 !== 8'h00) begin n_bad++; $display("FAIL reset_do0: got %h want 00", do0); end
    n_cmp++; if (wp0 !== 1'b0) begin n_bad++; $display("FAIL reset_wp0: got %b want 0", wp0); end
    n_cmp++; if (rdy3 !== 1'b0 || do3 !== 8'h00) begin
      n_bad++; $display("FAIL reset_ws3: got rdy=%b do=%h want 0/00", rdy3, do3);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_ws0();
    logic [7:0] dout, exp;
    int lat;
    logic wpf;
    load(8'hE0, 8'h01);
    exp_q.push_back(8'h01);
    drive_req(0, 8'hE0, 1'b0, 8'h00, dout, lat, wpf);
    exp = exp_q.pop_front();
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ws0_latency: got %0d want 1", lat); end
    n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL ws0_read: got %h want %h", dout, exp); end
    @(negedge clk);
    n_cmp++; if (rdy0 !== 1'b0 || do0 !== exp) begin
      n_bad++; $display("FAIL ws0_hold: got rdy=%b do=%h want 0/%h", rdy0, do0, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pre [4];
    logic [7:0] exp;
    pre = '{8'h40, 8'h62, 8'h80, 8'hC0};
    for (int i = 0; i < 4; i++) load(8'(i), pre[i]);
    addr = 8'h00; we = 1'b0; req0 = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(pre[i]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy[%0d]: got %b want 1", i, rdy0); end
      n_cmp++; if (do0 !== exp) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, do0, exp); end
      addr = 8'(i + 1);
    end
    req0 = 1'b0;
    @(negedge clk);
    n_cmp++; if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got %b want 0", rdy0); end
  endtask

  task automatic test_wait_states();
    logic [7:0] dout, exp;
    int lat;
    logic wpf;
    addr = 8'hE2; we = 1'b1; data_in = 8'h5A; req3 = 1'b1;
    exp_q.push_back(8'h5A);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin addr = 8'h00; data_in = 8'hFF; end
      if (c < 4) begin
        n_cmp++; if (rdy3 !== 1'b0) begin n_bad++; $display("FAIL ws3_early[%0d]: got %b want 0", c, rdy3); end
      end else begin
        exp = exp_q.pop_front();
        n_cmp++; if (rdy3 !== 1'b1) begin n_bad++; $display("FAIL ws3_rdy: got %b want 1", rdy3); end
        n_cmp++; if (do3 !== exp) begin n_bad++; $display("FAIL ws3_data: got %h want %h", do3, exp); end
        req3 = 1'b0; we = 1'b0;
      end
    end
    exp_q.push_back(8'h40);
    drive_req(3, 8'h00, 1'b0, 8'h00, dout, lat, wpf);
    exp = exp_q.pop_front();
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ws3_latency: got %0d want 4", lat); end
    n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL ws3_addr0_untouched: got %h want %h", dout, exp); end
    exp_q.push_back(8'h5A);
    drive_req(3, 8'hE2, 1'b0, 8'h00, dout, lat, wpf);
    exp = exp_q.pop_front();
    n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL ws3_readback: got %h want %h", dout, exp); end
  endtask

  task automatic test_collision();
    logic [7:0] dout, exp;
    int lat;
    logic wpf;
    ld_en = 1'b1; ld_addr = 8'h10; ld_data = 8'hAA;
    addr = 8'h10; we = 1'b1; data_in = 8'h55; req0 = 1'b1;
    exp_q.push_back(8'hAA);
    @(negedge clk);
    ld_en = 1'b0; req0 = 1'b0; we = 1'b0;
    exp = exp_q.pop_front();
    n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL coll_rdy: got %b want 1", rdy0); end
    n_cmp++; if (do0 !== exp) begin n_bad++; $display("FAIL coll_write_data: got %h want %h", do0, exp); end
    exp_q.push_back(8'hAA);
    drive_req(0, 8'h10, 1'b0, 8'h00, dout, lat, wpf);
    exp = exp_q.pop_front();
    n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL coll_readback: got %h want %h", dout, exp); end
    ld_en = 1'b1; ld_addr = 8'h11; ld_data = 8'h3C;
    addr = 8'h11; req0 = 1'b1;
    exp_q.push_back(8'h3C);
    @(negedge clk);
    ld_en = 1'b0; req0 = 1'b0;
    exp = exp_q.pop_front();
    n_cmp++; if (rdy0 !== 1'b1 || do0 !== exp) begin
      n_bad++; $display("FAIL coll_read: got rdy=%b do=%h want 1/%h", rdy0, do0, exp);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] dout, exp;
    int lat, pulses;
    logic wpf;
    load(8'h20, 8'h33);
    exp_q.push_back(8'h33);
    drive_req(2, 8'h20, 1'b0, 8'h00, dout, lat, wpf);
    exp = exp_q.pop_front();
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL ws2_latency: got %0d want 3", lat); end
    n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL ws2_read: got %h want %h", dout, exp); end
    addr = 8'h20; we = 1'b1; data_in = 8'h77; req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0; we = 1'b0; rst = 1'b0;
    #1;
    n_cmp++; if (rdy2 !== 1'b0 || do2 !== 8'h00 || wp2 !== 1'b0) begin
      n_bad++; $display("FAIL abort_outputs: got rdy=%b do=%h wp=%b want 0/00/0", rdy2, do2, wp2);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rdy2) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort_no_ready: got %0d pulses want 0", pulses); end
    exp_q.push_back(8'h33);
    drive_req(2, 8'h20, 1'b0, 8'h00, dout, lat, wpf);
    exp = exp_q.pop_front();
    n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL abort_mem_kept: got %h want %h", dout, exp); end
  endtask

  task automatic test_write_protect();
    logic [7:0] dout, exp;
    int lat;
    logic wpf;
    load(8'h03, 8'h80);
    exp_q.push_back(WP_ON ? 8'h80 : 8'hFF);
    drive_req(0, 8'h03, 1'b1, 8'hFF, dout, lat, wpf);
    exp = exp_q.pop_front();
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wp_latency: got %0d want 1", lat); end
    n_cmp++; if (wpf !== WP_ON) begin n_bad++; $display("FAIL wp_fault: got %b want %b", wpf, WP_ON); end
    n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL wp_data: got %h want %h", dout, exp); end
    @(negedge clk);
    n_cmp++; if (wp0 !== 1'b0) begin n_bad++; $display("FAIL wp_pulse_width: got %b want 0", wp0); end
    exp_q.push_back(8'h12);
    drive_req(0, 8'h08, 1'b1, 8'h12, dout, lat, wpf);
    exp = exp_q.pop_front();
    n_cmp++; if (wpf !== 1'b0 || dout !== exp) begin
      n_bad++; $display("FAIL wp_boundary: got wp=%b do=%h want 0/%h", wpf, dout, exp);
    end
    exp_q.push_back(WP_ON ? 8'h80 : 8'hFF);
    drive_req(0, 8'h03, 1'b0, 8'h00, dout, lat, wpf);
    exp = exp_q.pop_front();
    n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL wp_readback: got %h want %h", dout, exp); end
  endtask

  initial begin
    test_reset();
    test_read_ws0();
    test_back_to_back();
    test_wait_states();
    test_collision();
    test_reset_abort();
    test_write_protect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
